key_debouncer: RTL and testbench
================================

Name: key_debouncer

Overview:
- Front-end conditioning stage for a raw board pushbutton.
- Synchronises the asynchronous `rawKey` into the `clk` domain and rejects contact bounce with a counter-qualified state machine.
- Outputs a clean debounced level, plus one-cycle press and release strobes.
- `keyLevel` feeds directly into the key pulse stage (the `inputKey` of the one-shot key pulse block).

Parameters:
- `STABLE_CYCLES`, 50000: consecutive extra clock samples the synchronised key must hold a new value before it is accepted (1 ms at 50 MHz). Legal range is `STABLE_CYCLES` >= 1.
- `CNT_WIDTH`, 16: debounce counter width. Must satisfy 2^`CNT_WIDTH` > `STABLE_CYCLES`.
- `ACTIVE_LOW`, 1: when 1, `rawKey`=0 means pressed (board KEY buttons); when 0, `rawKey`=1 means pressed.

Ports:
- `clk` input 1: system clock, all state on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rawKey` input 1: unsynchronised pushbutton pin.
- `keyLevel` output 1: debounced level, 1 = pressed.
- `keyPress` output 1: one-cycle strobe on an accepted press.
- `keyRelease` output 1: one-cycle strobe on an accepted release.

Behaviour:
- Reset (asynchronous, active-high):
  - Both synchroniser flops go to 0 (internal "released"). The inversion is applied before the first flop.
  - State goes to IDLE and the counter to 0.
  - `keyLevel`, `keyPress` and `keyRelease` go to 0 immediately, with no clock edge required.
- Synchroniser:
  - `s1` <= `rawKey` XOR `ACTIVE_LOW`; `s2` <= `s1`.
  - The FSM uses only `s2`.
  - `rawKey` never reaches any other logic.
- Counter: `CNT_WIDTH` bits, loaded with 1 on entry to a WAIT state, incremented by 1 per cycle while in WAIT, and never wraps. The FSM leaves WAIT on reaching `STABLE_CYCLES`.
- FSM (all outputs registered):
  - IDLE (`keyLevel`=0): `s2`=1 -> PRESS_WAIT, counter <= 1. Otherwise stay.
  - PRESS_WAIT (`keyLevel`=0):
    - `s2`=0 -> IDLE (bounce rejected, no strobe).
    - `s2`=1 and counter=`STABLE_CYCLES` -> PRESSED, `keyLevel` <= 1, `keyPress` <= 1.
    - Otherwise counter += 1.
  - PRESSED (`keyLevel`=1): `s2`=0 -> RELEASE_WAIT, counter <= 1. Otherwise stay.
  - RELEASE_WAIT (`keyLevel`=1):
    - `s2`=1 -> PRESSED (bounce rejected, no strobe).
    - `s2`=0 and counter=`STABLE_CYCLES` -> IDLE, `keyLevel` <= 0, `keyRelease` <= 1.
    - Otherwise counter += 1.
- Strobes: `keyPress` and `keyRelease` are high for exactly one cycle and are cleared on the next edge. They are never high together.
- Latency:
  - An accepted edge requires `rawKey` stable for `STABLE_CYCLES`+1 consecutive sampling edges.
  - `keyPress`/`keyRelease` and the `keyLevel` change appear on the (`STABLE_CYCLES`+3)th rising edge, counting the first edge that samples the new `rawKey` value as edge 1.
  - Any shorter glitch produces no output change.
- Held key: exactly one `keyPress` per accepted press, regardless of hold time. `keyLevel` stays 1 for the whole hold.
- Reset mid-operation: any WAIT progress is discarded.
  - If the key is still held at reset deassertion, it is treated as a new press and fully re-debounced.
  - `keyPress` then fires on edge `STABLE_CYCLES`+3 after deassertion.
- Illegal or unreachable state encodings return to IDLE with all outputs 0.

Test Plan (`STABLE_CYCLES`=4, `ACTIVE_LOW`=1, `clk` period 2):
1. Asynchronous reset: set `rawKey`=0 held; pulse `reset` high between clock edges -> `keyLevel`=`keyPress`=`keyRelease`=0 before the next edge. Then release `reset` with `rawKey`=0 held -> `keyPress` high for exactly one cycle after edge 7, and `keyLevel`=1 from edge 7 onward.
2. Clean press: `rawKey` 1->0, held 20 cycles -> `keyPress`=1 for exactly one cycle following edge 7, and `keyLevel` rises on the same edge. `keyRelease` stays 0 throughout.
3. Press bounce: from idle, drive `rawKey` low 3 cycles, high 1, low 4, then high -> `keyPress` never asserts and `keyLevel` stays 0 (neither low run reaches 5 samples).
4. Clean release: from the pressed state, `rawKey` 0->1 held 20 cycles -> `keyRelease`=1 for exactly one cycle following edge 7, and `keyLevel` falls on the same edge. No `keyPress`.
5. Release bounce: from the pressed state, drive `rawKey` high 2 cycles then low -> `keyLevel` remains 1, and `keyPress`=`keyRelease`=0 throughout.
6. Long hold: `rawKey`=0 for 200 cycles -> exactly one `keyPress` pulse. Then release with `rawKey`=1 for 10 cycles -> exactly one `keyRelease`. Total strobe counts are 1 and 1.

Source files
------------

// File: rtl/key_debouncer.sv
// Pushbutton conditioner: two-flop synchroniser plus a counter-qualified
// debounce FSM producing a clean level and one-cycle press/release strobes.
`timescale 1ns/1ps
module key_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic rawKey,
    output logic keyLevel,
    output logic keyPress,
    output logic keyRelease
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_TARGET = CNT_WIDTH'(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic                 s1;
    logic                 s2;
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 cnt_full;

    assign cnt_full = &cnt;

    // Polarity is normalised before the first flop so 1 always means pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= rawKey ^ ACTIVE_LOW;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            keyLevel   <= 1'b0;
            keyPress   <= 1'b0;
            keyRelease <= 1'b0;
        end else begin
            keyPress   <= 1'b0;
            keyRelease <= 1'b0;
            case (state)
                IDLE: begin
                    keyLevel <= 1'b0;
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    keyLevel <= 1'b0;
                    if (!s2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_TARGET) begin
                        state    <= PRESSED;
                        keyLevel <= 1'b1;
                        keyPress <= 1'b1;
                    end else if (!cnt_full) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    keyLevel <= 1'b1;
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    keyLevel <= 1'b1;
                    if (s2) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_TARGET) begin
                        state      <= IDLE;
                        keyLevel   <= 1'b0;
                        keyRelease <= 1'b1;
                    end else if (!cnt_full) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    keyLevel <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed test-plan steps then random bursts,
// all checked against a run-length model of the debounce rule.
`timescale 1ns/1ps
module tb_key_debouncer;

    localparam int S  = 4;
    localparam bit AL = 1'b1;

    logic clk;
    logic reset;
    logic rawKey;
    logic keyLevel;
    logic keyPress;
    logic keyRelease;

    int checks = 0;
    int errors = 0;

    // Model: 2-sample delay, then accept after S+1 samples differing from level.
    logic m_q1, m_q2, m_lvl, m_press, m_rel;
    int   m_run;

    int seg_edge, press_cnt, rel_cnt, first_press, first_rel;

    key_debouncer #(
        .STABLE_CYCLES(S),
        .CNT_WIDTH(16),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rawKey(rawKey),
        .keyLevel(keyLevel),
        .keyPress(keyPress),
        .keyRelease(keyRelease)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q1    = 1'b0;
        m_q2    = 1'b0;
        m_lvl   = 1'b0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_run   = 0;
    endtask

    task automatic model_edge(input logic raw);
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (m_q2 != m_lvl) begin
            m_run++;
            if (m_run == S + 1) begin
                m_lvl = ~m_lvl;
                if (m_lvl) m_press = 1'b1;
                else       m_rel   = 1'b1;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_q2 = m_q1;
        m_q1 = raw ^ AL;
    endtask

    task automatic seg();
        seg_edge    = 0;
        press_cnt   = 0;
        rel_cnt     = 0;
        first_press = 0;
        first_rel   = 0;
    endtask

    task automatic tick(input logic raw);
        rawKey = raw;
        @(posedge clk);
        model_edge(raw);
        seg_edge++;
        @(negedge clk);
        check("level", keyLevel, m_lvl);
        check("press", keyPress, m_press);
        check("release", keyRelease, m_rel);
        if (keyPress) begin
            press_cnt++;
            if (first_press == 0) first_press = seg_edge;
        end
        if (keyRelease) begin
            rel_cnt++;
            if (first_rel == 0) first_rel = seg_edge;
        end
    endtask

    task automatic run(input logic raw, input int n);
        for (int i = 0; i < n; i++) tick(raw);
    endtask

    initial begin
        reset  = 1'b1;
        rawKey = 1'b1;
        model_reset();
        seg();
        repeat (3) @(negedge clk);
        check("rst_level", keyLevel, 1'b0);
        check("rst_press", keyPress, 1'b0);
        check("rst_release", keyRelease, 1'b0);
        reset = 1'b0;
        run(1'b1, 5);

        // Clean press
        seg();
        run(1'b0, 20);
        check_int("press_edge", first_press, S + 3);
        check_int("press_count", press_cnt, 1);
        check_int("press_no_rel", rel_cnt, 0);
        check("press_level", keyLevel, 1'b1);

        // Release bounce
        seg();
        run(1'b1, 2);
        run(1'b0, 10);
        check_int("rbounce_rel", rel_cnt, 0);
        check_int("rbounce_press", press_cnt, 0);
        check("rbounce_level", keyLevel, 1'b1);

        // Clean release
        seg();
        run(1'b1, 20);
        check_int("rel_edge", first_rel, S + 3);
        check_int("rel_count", rel_cnt, 1);
        check_int("rel_no_press", press_cnt, 0);
        check("rel_level", keyLevel, 1'b0);

        // Press bounce
        seg();
        run(1'b0, 3);
        run(1'b1, 1);
        run(1'b0, 4);
        run(1'b1, 10);
        check_int("pbounce_press", press_cnt, 0);
        check("pbounce_level", keyLevel, 1'b0);

        // Asynchronous reset while pressed, key still held afterwards
        run(1'b0, 20);
        check("pre_async_level", keyLevel, 1'b1);
        #0.5;
        reset = 1'b1;
        model_reset();
        #0.2;
        check("async_level", keyLevel, 1'b0);
        check("async_press", keyPress, 1'b0);
        check("async_release", keyRelease, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        seg();
        run(1'b0, 20);
        check_int("rearm_edge", first_press, S + 3);
        check_int("rearm_count", press_cnt, 1);

        // Long hold
        run(1'b1, 10);
        seg();
        run(1'b0, 200);
        run(1'b1, 10);
        check_int("hold_press", press_cnt, 1);
        check_int("hold_rel", rel_cnt, 1);

        // Random bursts
        for (int k = 0; k < 60; k++) begin
            run(1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
